// File: rtl/pipeline_pkg.sv
// Shared decode constants and multdiv state type for the five-stage pipeline controller.
package pipeline_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam int OP_LSB    = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int ALUOP_LSB = 2;

  localparam logic [31:0] NOP = 32'b0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  function automatic logic is_md(input logic [31:0] insn);
    logic [4:0] op;
    logic [4:0] aluop;
    op    = insn[OP_LSB +: 5];
    aluop = insn[ALUOP_LSB +: 5];
    return (op == OP_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: decodes the FD source registers and compares them
// against the destination of a load sitting in DX.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  output logic        load_use
);

  logic [4:0] fd_op;
  logic [4:0] fd_rd;
  logic [4:0] fd_rs;
  logic [4:0] fd_rt;
  logic [4:0] dx_rd;
  logic       use_rd;
  logic       use_rs;
  logic       use_rt;
  logic       unused_bits;

  assign unused_bits = ^{fd_insn[11:0], dx_insn[21:0]};

  always_comb begin
    fd_op  = fd_insn[OP_LSB +: 5];
    fd_rd  = fd_insn[RD_LSB +: 5];
    fd_rs  = fd_insn[RS_LSB +: 5];
    fd_rt  = fd_insn[RT_LSB +: 5];
    dx_rd  = dx_insn[RD_LSB +: 5];
    use_rd = 1'b0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (fd_op)
      OP_RTYPE:              begin use_rs = 1'b1; use_rt = 1'b1; end
      OP_ADDI, OP_LW:        use_rs = 1'b1;
      OP_SW, OP_BNE, OP_BLT: begin use_rd = 1'b1; use_rs = 1'b1; end
      OP_JR:                 use_rd = 1'b1;
      OP_J, OP_JAL:          use_rd = 1'b0;
      default:               use_rd = 1'b0;
    endcase
    // r0 is hardwired, so a load targeting it never creates a dependency.
    load_use = (dx_insn[OP_LSB +: 5] == OP_LW) && (dx_rd != 5'd0) &&
               ((use_rd && (fd_rd == dx_rd)) ||
                (use_rs && (fd_rs == dx_rd)) ||
                (use_rt && (fd_rt == dx_rd)));
  end

endmodule

// File: rtl/pipeline_control.sv
// Pipeline hazard/sequencing controller: latch enables and flushes, multdiv launch and
// timeout, and a saturating stall-cycle counter. Controls are combinational on FSM state.
module pipeline_control
  import pipeline_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_insn,
  input  logic [31:0]      dx_insn,
  input  logic             x_redirect,
  input  logic             md_ready,
  output logic             md_start,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_en,
  output logic             dx_flush,
  output logic             xm_flush,
  output logic             mw_en,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int BW = $clog2(MD_TIMEOUT + 1);

  md_state_e        state_q, state_d;
  logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             rst_q;

  logic load_use;
  logic dx_is_md;
  logic active;
  logic busy;
  logic launch;
  logic done;
  logic tmo;
  logic busy_stall;
  logic redirect_ok;
  logic stall;

  hazard_detect u_hazard (
    .fd_insn  (fd_insn),
    .dx_insn  (dx_insn),
    .load_use (load_use)
  );

  always_comb begin
    dx_is_md    = is_md(dx_insn);
    // Outputs stay low while reset is high and for the cycle after it was sampled.
    active      = !reset && !rst_q;
    busy        = (state_q == BUSY);
    launch      = active && !busy && dx_is_md;
    done        = busy && md_ready;
    tmo         = busy && !md_ready && (busy_cnt_q == BW'(MD_TIMEOUT));
    busy_stall  = launch || (busy && !done && !tmo);
    redirect_ok = x_redirect && !dx_is_md;
    stall       = active && (busy_stall || (load_use && !redirect_ok));

    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    if (launch) begin
      state_d    = BUSY;
      busy_cnt_d = BW'(1);
    end else if (done || tmo) begin
      state_d    = IDLE;
      busy_cnt_d = '0;
    end else if (busy) begin
      busy_cnt_d = busy_cnt_q + BW'(1);
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    md_start   = 1'b0;
    pc_en      = 1'b1;
    pc_sel     = 1'b0;
    fd_en      = 1'b1;
    fd_flush   = 1'b0;
    dx_en      = 1'b1;
    dx_flush   = 1'b0;
    xm_flush   = 1'b0;
    mw_en      = 1'b1;
    md_busy    = busy;
    md_timeout = tmo;
    if (busy_stall) begin
      md_start = launch;
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      dx_en    = 1'b0;
      xm_flush = 1'b1;
    end else if (redirect_ok) begin
      pc_sel   = 1'b1;
      fd_flush = 1'b1;
      dx_flush = 1'b1;
    end else if (load_use) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      dx_flush = 1'b1;
    end

    if (!active) begin
      md_start   = 1'b0;
      pc_en      = 1'b0;
      pc_sel     = 1'b0;
      fd_en      = 1'b0;
      fd_flush   = 1'b0;
      dx_en      = 1'b0;
      dx_flush   = 1'b0;
      xm_flush   = 1'b0;
      mw_en      = 1'b0;
      md_busy    = 1'b0;
      md_timeout = 1'b0;
    end
  end

  assign stall_count = stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
      rst_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      rst_q       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Scenario bench for pipeline_control: per-cycle expected control vectors and stall count
// are queued as stimulus is applied and checked at the falling edge.
module tb_pipeline_control;

  localparam int CW = 6;

  localparam logic [4:0] T_R    = 5'b00000;
  localparam logic [4:0] T_J    = 5'b00001;
  localparam logic [4:0] T_BNE  = 5'b00010;
  localparam logic [4:0] T_JAL  = 5'b00011;
  localparam logic [4:0] T_JR   = 5'b00100;
  localparam logic [4:0] T_ADDI = 5'b00101;
  localparam logic [4:0] T_BLT  = 5'b00110;
  localparam logic [4:0] T_SW   = 5'b00111;
  localparam logic [4:0] T_LW   = 5'b01000;
  localparam logic [31:0] T_NOP = 32'b0;

  // {md_start, pc_en, pc_sel, fd_en, fd_flush, dx_en, dx_flush, xm_flush, mw_en, md_busy, md_timeout}
  localparam logic [10:0] C_RESET  = 11'b0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] C_RUN    = 11'b0_1_0_1_0_1_0_0_1_0_0;
  localparam logic [10:0] C_LU     = 11'b0_0_0_0_0_1_1_0_1_0_0;
  localparam logic [10:0] C_REDIR  = 11'b0_1_1_1_1_1_1_0_1_0_0;
  localparam logic [10:0] C_LAUNCH = 11'b1_0_0_0_0_0_0_1_1_0_0;
  localparam logic [10:0] C_BUSY   = 11'b0_0_0_0_0_0_0_1_1_1_0;
  localparam logic [10:0] C_DONE   = 11'b0_1_0_1_0_1_0_0_1_1_0;
  localparam logic [10:0] C_TMO    = 11'b0_1_0_1_0_1_0_0_1_1_1;

  typedef struct {
    logic        rst;
    logic [31:0] fd;
    logic [31:0] dx;
    logic        redir;
    logic        rdy;
    logic [10:0] e;
  } stim_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   fd_insn = 32'b0;
  logic [31:0]   dx_insn = 32'b0;
  logic          x_redirect = 1'b0;
  logic          md_ready = 1'b0;
  logic          md_start, pc_en, pc_sel, fd_en, fd_flush, dx_en, dx_flush;
  logic          xm_flush, mw_en, md_busy, md_timeout;
  logic [CW-1:0] stall_count;
  logic [10:0]   ctl;

  logic [10:0]   exp_q[$];
  logic [CW-1:0] exp_stall = '0;
  logic          pend_stall = 1'b0;
  logic          prev_rst = 1'b1;
  int            checks = 0;
  int            failures = 0;

  always #5 clock = ~clock;

  pipeline_control #(.MD_TIMEOUT(40), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .fd_insn     (fd_insn),
    .dx_insn     (dx_insn),
    .x_redirect  (x_redirect),
    .md_ready    (md_ready),
    .md_start    (md_start),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .fd_en       (fd_en),
    .fd_flush    (fd_flush),
    .dx_en       (dx_en),
    .dx_flush    (dx_flush),
    .xm_flush    (xm_flush),
    .mw_en       (mw_en),
    .md_busy     (md_busy),
    .md_timeout  (md_timeout),
    .stall_count (stall_count)
  );

  assign ctl = {md_start, pc_en, pc_sel, fd_en, fd_flush, dx_en, dx_flush,
                xm_flush, mw_en, md_busy, md_timeout};

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] aluop);
    return {op, rd, rs, rt, 5'b0, aluop, 2'b0};
  endfunction

  function automatic stim_t st(input logic rst, input logic [31:0] fd, input logic [31:0] dx,
                               input logic redir, input logic rdy, input logic [10:0] e);
    stim_t s;
    s.rst = rst; s.fd = fd; s.dx = dx; s.redir = redir; s.rdy = rdy; s.e = e;
    return s;
  endfunction

  // Source-register usage of an FD instruction, written from the ISA table.
  function automatic bit reads_reg(input logic [31:0] insn, input logic [4:0] r);
    logic [4:0] op, rd, rs, rt;
    op = insn[31:27]; rd = insn[26:22]; rs = insn[21:17]; rt = insn[16:12];
    case (op)
      T_R:                return (rs == r) || (rt == r);
      T_ADDI, T_LW:       return rs == r;
      T_SW, T_BNE, T_BLT: return (rd == r) || (rs == r);
      T_JR:               return rd == r;
      default:            return 1'b0;
    endcase
  endfunction

  // Drives one cycle; a cycle whose expected vector holds the PC (outside reset) is a stall.
  task automatic apply(input stim_t s);
    @(posedge clock);
    if (prev_rst) exp_stall = '0;
    else if (pend_stall && exp_stall != {CW{1'b1}}) exp_stall = exp_stall + 1'b1;
    #1;
    reset      = s.rst;
    fd_insn    = s.fd;
    dx_insn    = s.dx;
    x_redirect = s.redir;
    md_ready   = s.rdy;
    exp_q.push_back(s.e);
    pend_stall = !s.rst && (s.e != C_RESET) && !s.e[9];
    prev_rst   = s.rst;
    @(negedge clock);
  endtask

  task automatic test_reset_busy();
    stim_t seq[$];
    logic [10:0] e;
    logic [31:0] mul = mk(T_R, 5'd3, 5'd1, 5'd2, 5'b00110);
    logic [31:0] add = mk(T_R, 5'd3, 5'd1, 5'd2, 5'b00000);
    seq.push_back(st(0, T_NOP, T_NOP, 0, 0, C_RESET));
    seq.push_back(st(0, T_NOP, mul, 0, 0, C_LAUNCH));
    for (int i = 0; i < 5; i++) seq.push_back(st(0, T_NOP, mul, 0, 0, C_BUSY));
    seq.push_back(st(1, T_NOP, mul, 0, 0, C_RESET));
    seq.push_back(st(0, T_NOP, add, 0, 0, C_RESET));
    seq.push_back(st(0, T_NOP, add, 0, 0, C_RUN));
    for (int i = 0; i < seq.size(); i++) begin
      apply(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if ({ctl, stall_count} !== {e, exp_stall}) begin
        failures++;
        $display("FAIL reset_busy[%0d] ctl=%b stall=%0d expected ctl=%b stall=%0d",
                 i, ctl, stall_count, e, exp_stall);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t seq[$];
    logic [10:0] e;
    seq.push_back(st(0, mk(T_R, 1, 5, 2, 0), mk(T_LW, 5, 3, 0, 0), 0, 0, C_LU));
    seq.push_back(st(0, mk(T_R, 1, 5, 2, 0), T_NOP, 0, 0, C_RUN));
    seq.push_back(st(0, mk(T_R, 1, 0, 2, 0), mk(T_LW, 0, 3, 0, 0), 0, 0, C_RUN));
    seq.push_back(st(0, mk(T_SW, 5, 1, 0, 0), mk(T_LW, 5, 3, 0, 0), 0, 0, C_LU));
    seq.push_back(st(0, mk(T_ADDI, 1, 2, 5, 0), mk(T_LW, 5, 3, 0, 0), 0, 0, C_RUN));
    seq.push_back(st(0, mk(T_J, 5, 5, 5, 0), mk(T_LW, 5, 3, 0, 0), 0, 0, C_RUN));
    seq.push_back(st(0, mk(T_JR, 7, 0, 0, 0), mk(T_LW, 7, 3, 0, 0), 0, 0, C_LU));
    seq.push_back(st(0, mk(T_R, 1, 5, 2, 0), mk(T_ADDI, 5, 3, 0, 0), 0, 0, C_RUN));
    for (int i = 0; i < seq.size(); i++) begin
      apply(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if ({ctl, stall_count} !== {e, exp_stall}) begin
        failures++;
        $display("FAIL load_use[%0d] ctl=%b stall=%0d expected ctl=%b stall=%0d",
                 i, ctl, stall_count, e, exp_stall);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t seq[$];
    logic [10:0] e;
    seq.push_back(st(0, mk(T_SW, 4, 1, 0, 0), mk(T_BNE, 2, 3, 0, 0), 1, 0, C_REDIR));
    seq.push_back(st(0, mk(T_R, 1, 5, 2, 0), mk(T_LW, 5, 3, 0, 0), 1, 0, C_REDIR));
    seq.push_back(st(0, mk(T_SW, 4, 1, 0, 0), mk(T_BLT, 2, 3, 0, 0), 0, 0, C_RUN));
    for (int i = 0; i < seq.size(); i++) begin
      apply(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if ({ctl, stall_count} !== {e, exp_stall}) begin
        failures++;
        $display("FAIL redirect[%0d] ctl=%b stall=%0d expected ctl=%b stall=%0d",
                 i, ctl, stall_count, e, exp_stall);
      end
    end
  endtask

  task automatic test_mul();
    stim_t seq[$];
    logic [10:0] e;
    logic [31:0] mul = mk(T_R, 6, 1, 2, 5'b00110);
    seq.push_back(st(0, T_NOP, mul, 1, 0, C_LAUNCH));
    for (int i = 0; i < 16; i++) seq.push_back(st(0, T_NOP, mul, 0, 0, C_BUSY));
    seq.push_back(st(0, T_NOP, mul, 1, 1, C_DONE));
    seq.push_back(st(0, T_NOP, mk(T_R, 1, 2, 3, 0), 0, 0, C_RUN));
    for (int i = 0; i < seq.size(); i++) begin
      apply(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if ({ctl, stall_count} !== {e, exp_stall}) begin
        failures++;
        $display("FAIL mul[%0d] ctl=%b stall=%0d expected ctl=%b stall=%0d",
                 i, ctl, stall_count, e, exp_stall);
      end
    end
  endtask

  task automatic test_div_timeout();
    stim_t seq[$];
    logic [10:0] e;
    logic [31:0] div = mk(T_R, 6, 1, 2, 5'b00111);
    seq.push_back(st(0, T_NOP, div, 0, 0, C_LAUNCH));
    for (int i = 0; i < 39; i++) seq.push_back(st(0, T_NOP, div, 0, 0, C_BUSY));
    seq.push_back(st(0, T_NOP, div, 0, 0, C_TMO));
    seq.push_back(st(0, T_NOP, mk(T_ADDI, 1, 2, 0, 0), 0, 0, C_RUN));
    for (int i = 0; i < seq.size(); i++) begin
      apply(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if ({ctl, stall_count} !== {e, exp_stall}) begin
        failures++;
        $display("FAIL div_timeout[%0d] ctl=%b stall=%0d expected ctl=%b stall=%0d",
                 i, ctl, stall_count, e, exp_stall);
      end
    end
  endtask

  // Stall counter crosses its all-ones limit during this scenario.
  task automatic test_busy_hazard();
    stim_t seq[$];
    logic [10:0] e;
    logic [31:0] mul = mk(T_R, 6, 1, 2, 5'b00110);
    logic [31:0] lw5 = mk(T_LW, 5, 3, 0, 0);
    logic [31:0] use5 = mk(T_R, 1, 5, 2, 0);
    seq.push_back(st(0, use5, mul, 0, 0, C_LAUNCH));
    for (int i = 0; i < 3; i++) seq.push_back(st(0, use5, lw5, 0, 0, C_BUSY));
    for (int i = 0; i < 2; i++) seq.push_back(st(0, use5, mul, 0, 0, C_BUSY));
    seq.push_back(st(0, use5, mul, 0, 1, C_DONE));
    seq.push_back(st(0, use5, lw5, 0, 0, C_LU));
    seq.push_back(st(0, use5, T_NOP, 0, 0, C_RUN));
    for (int i = 0; i < 4; i++) seq.push_back(st(0, use5, lw5, 0, 0, C_LU));
    seq.push_back(st(0, use5, T_NOP, 0, 0, C_RUN));
    for (int i = 0; i < seq.size(); i++) begin
      apply(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if ({ctl, stall_count} !== {e, exp_stall}) begin
        failures++;
        $display("FAIL busy_hazard[%0d] ctl=%b stall=%0d expected ctl=%b stall=%0d",
                 i, ctl, stall_count, e, exp_stall);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t seq[$];
    logic [10:0] e;
    logic [4:0] ops[9] = '{T_R, T_J, T_BNE, T_JAL, T_JR, T_ADDI, T_BLT, T_SW, T_LW};
    logic [31:0] fd, dx;
    logic [4:0] drd;
    bit is_lw;
    for (int i = 0; i < 40; i++) begin
      fd    = mk(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 5)));
      drd   = 5'($urandom_range(0, 7));
      is_lw = ($urandom_range(0, 3) != 0);
      dx    = mk(is_lw ? T_LW : T_ADDI, drd, 5'($urandom_range(0, 7)), 5'd0, 5'd0);
      seq.push_back(st(0, fd, dx, 0, 0,
                       (is_lw && drd != 5'd0 && reads_reg(fd, drd)) ? C_LU : C_RUN));
    end
    for (int i = 0; i < seq.size(); i++) begin
      apply(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if ({ctl, stall_count} !== {e, exp_stall}) begin
        failures++;
        $display("FAIL back_to_back[%0d] fd=%h dx=%h ctl=%b stall=%0d expected ctl=%b stall=%0d",
                 i, seq[i].fd, seq[i].dx, ctl, stall_count, e, exp_stall);
      end
    end
  endtask

  task automatic test_reset();
    logic [10:0] e;
    repeat (2) @(posedge clock);
    exp_q.push_back(C_RESET);
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if ({ctl, stall_count} !== {e, {CW{1'b0}}}) begin
      failures++;
      $display("FAIL reset ctl=%b stall=%0d expected ctl=%b stall=0", ctl, stall_count, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_busy();
    test_load_use();
    test_redirect();
    test_mul();
    test_div_timeout();
    test_busy_hazard();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
